// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer that shares one external combinational 8-bit ALU between two
// requesters. Each op runs accept (IDLE) -> drive ALU (EXEC) -> hold tagged response (RESP).
module alu_share_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       req0_valid,
   output logic       req0_ready,
   input  logic [7:0] req0_a,
   input  logic [7:0] req0_b,
   input  logic [1:0] req0_op,
   input  logic       req1_valid,
   output logic       req1_ready,
   input  logic [7:0] req1_a,
   input  logic [7:0] req1_b,
   input  logic [1:0] req1_op,
   output logic [7:0] alu_a,
   output logic [7:0] alu_b,
   output logic [1:0] alu_ctrl,
   input  logic [7:0] alu_out,
   output logic       rsp_valid,
   input  logic       rsp_ready,
   output logic [7:0] rsp_data,
   output logic       rsp_id,
   output logic       rsp_err,
   output logic       busy,
   output logic [7:0] op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t          state;
   logic            last_grant;
   logic            gnt;
   logic            acc_ok;
   logic            accept;
   logic            id_q;
   logic            err_q;
   logic [1:0][7:0] ra;
   logic [1:0][7:0] rb;
   logic [1:0][1:0] rop;

   assign ra  = {req1_a, req0_a};
   assign rb  = {req1_b, req0_b};
   assign rop = {req1_op, req0_op};

   // On a tie the requester not granted last wins.
   always_comb begin
      gnt = 1'b0;
      if (req0_valid & req1_valid) gnt = ~last_grant;
      else                         gnt = req1_valid;
   end

   assign acc_ok     = (state == IDLE) & ~rst;
   assign req0_ready = acc_ok & req0_valid & ~gnt;
   assign req1_ready = acc_ok & req1_valid & gnt;
   assign accept     = req0_ready | req1_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_ctrl   <= '0;
         id_q       <= 1'b0;
         err_q      <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_data   <= '0;
         rsp_id     <= 1'b0;
         rsp_err    <= 1'b0;
         busy       <= 1'b0;
         op_count   <= '0;
      end else begin
         case (state)
            IDLE: if (accept) begin
               // Illegal op 11 is steered to add so the ALU never sees its undefined case.
               alu_a      <= ra[gnt];
               alu_b      <= rb[gnt];
               alu_ctrl   <= (rop[gnt] == 2'b11) ? 2'b00 : rop[gnt];
               err_q      <= (rop[gnt] == 2'b11);
               id_q       <= gnt;
               last_grant <= gnt;
               busy       <= 1'b1;
               state      <= EXEC;
            end
            EXEC: begin
               rsp_data  <= err_q ? 8'h00 : alu_out;
               rsp_id    <= id_q;
               rsp_err   <= err_q;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: if (rsp_ready) begin
               rsp_valid <= 1'b0;
               busy      <= 1'b0;
               op_count  <= op_count + 8'd1;
               state     <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencing arbiter that shares the single combinational 8-bit ALU (add/and/sub) between two requesters. It accepts operation requests over valid/ready handshakes and grants them round-robin. It drives the ALU operand and control inputs from registered values, captures the ALU result, and returns it on a tagged response channel with backpressure. The block sits between the instruction-issue logic and the ALU; the ALU itself is instantiated alongside it, not inside it.

## Interface
Parameters:
- none (widths fixed: 8-bit data, 2-bit opcode)

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `req0_valid` / `req1_valid`  in  1  requester 0/1 has an operation pending
- `req0_ready` / `req1_ready`  out  1  requester 0/1 transfer accepted this cycle
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  8  operands
- `req0_op` / `req1_op`  in  2  00 add, 01 and, 10 sub, 11 illegal
- `alu_a`, `alu_b`  out  8  to ALU operand inputs (registered)
- `alu_ctrl`  out  2  to ALU control (registered)
- `alu_out`  in  8  combinational ALU result
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  consumer accepts response
- `rsp_data`  out  8  result
- `rsp_id`  out  1  requester that issued the op
- `rsp_err`  out  1  op was illegal (11)
- `busy`  out  1  state ≠ IDLE
- `op_count`  out  8  completed-response counter

## Operation
- FSM states:
  - IDLE: wait for a request; on accept (`reqN_valid & reqN_ready`), latch `a`, `b`, `op` and the id, then go to EXEC.
  - EXEC: drive the latched values on `alu_a`/`alu_b`/`alu_ctrl`; at the end of the cycle capture `alu_out` into `rsp_data`; go to RESP.
  - RESP: hold `rsp_valid=1`; on `rsp_ready`, go to IDLE.
- Grant is combinational in IDLE only:
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester not granted last wins.
  - `last_grant` updates only on accept.
- `reqN_ready` = IDLE & grant==N & !rst. At most one ready is high per cycle. Both are 0 outside IDLE.
- Illegal op 11:
  - It is still accepted and passes through EXEC.
  - `alu_ctrl` is driven 00, the result is discarded, and `rsp_data`=0 with `rsp_err`=1.
  - It never reaches the ALU's undefined case.
- Arithmetic is 8-bit modulo 2^8 with no carry or borrow out: 0xFF+0x01=0x00, 0x00−0x01=0xFF.
- `alu_a`/`alu_b`/`alu_ctrl` hold their last value outside EXEC; no glitching.
- `op_count` increments on each `rsp_valid & rsp_ready`, including errors. It wraps from 0xFF to 0x00.
- `rsp_data`/`rsp_id`/`rsp_err` stay stable while `rsp_valid=1 & !rsp_ready`.

## Timing
- Reset (any cycle, including mid-EXEC or mid-RESP):
  - State goes to IDLE on the next edge; any in-flight op is dropped with no response.
  - All outputs are 0: `req*_ready`, `alu_a`, `alu_b`, `alu_ctrl`, `rsp_valid`, `rsp_data`, `rsp_id`, `rsp_err`, `busy`, `op_count`.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
- Latency:
  - Accept at cycle T (IDLE).
  - EXEC at T+1.
  - `rsp_valid` first high at T+2.
  - With `rsp_ready=1` at T+2, IDLE at T+3, and the next accept is possible at T+3.
- Minimum issue interval is 3 cycles per op.
- `rsp_valid` does not depend combinationally on `rsp_ready`.
- `req*_ready` depends combinationally on `req*_valid` (same-cycle grant).

## Test plan
- Reset then single op:
  - Stimulus: req0 a=0x12, b=0x34, op=00, `rsp_ready`=1.
  - Response: `req0_ready` at T, `alu_ctrl`=00 and `alu_a`=0x12 at T+1, `rsp_valid`=1, `rsp_data`=0x46, `rsp_id`=0 at T+2, `op_count`=1.
- Wrap and sub:
  - req1 0xFF+0x01 -> `rsp_data`=0x00, `rsp_id`=1.
  - req1 0x00−0x01 (op 10) -> 0xFF.
  - AND 0xF0&0x3C -> 0x30.
- Contention:
  - Stimulus: both requesters valid continuously for 4 ops.
  - Response: grants alternate 0,1,0,1 after reset; each accept is 3 cycles apart.
- Backpressure:
  - Stimulus: hold `rsp_ready`=0 for 5 cycles in RESP.
  - Response: `rsp_valid`, `rsp_data` and `rsp_id` stable; both `req*_ready`=0; `busy`=1; completion on the first cycle `rsp_ready`=1.
- Illegal op:
  - Stimulus: req0 op=11, a=0x55.
  - Response: `alu_ctrl`=00 in EXEC, `rsp_err`=1, `rsp_data`=0x00, `op_count` increments.
- Reset mid-operation:
  - Stimulus: assert `rst` during EXEC.
  - Response: next cycle all outputs are 0, no response is emitted, and the next tie is granted to requester 0.
  - After 256 completions, `op_count` reads 0x00.
